// File: rtl/frequency_meter.sv
// Gated rising-edge counter: counts synchronised sig_in rising edges over GATE_CYCLES clocks
// and reports the saturating count with a one-cycle valid pulse.
module frequency_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 32,
  parameter int CONTINUOUS  = 0
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  localparam int GATE_W = $clog2(GATE_CYCLES + 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, dly_q;
  logic                rise;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [CNT_W-1:0]    edge_q, edge_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    freq_q, freq_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;
  logic [CNT_W:0]      edge_inc;

  // Returns {saturated_now, next_count}; the count sticks at CNT_MAX.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] cnt, input logic inc);
    if (inc && (cnt == CNT_MAX)) begin
      return {1'b1, cnt};
    end
    return {1'b0, cnt + CNT_W'(inc)};
  endfunction

  assign rise     = sync2_q & ~dly_q;
  assign edge_inc = sat_add(edge_q, rise);

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
      gate_q  <= '0;
      edge_q  <= '0;
      sat_q   <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      sat_q   <= sat_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start || (CONTINUOUS != 0)) state_d = GATE;
      GATE:    if (gate_q == GATE_LAST) state_d = DONE;
      DONE:    state_d = (CONTINUOUS != 0) ? GATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers load on the last gate cycle so they are visible during DONE.
  always_comb begin
    gate_d  = '0;
    edge_d  = '0;
    sat_d   = 1'b0;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (state_q == GATE) begin
      gate_d = gate_q + GATE_W'(1);
      edge_d = edge_inc[CNT_W-1:0];
      sat_d  = sat_q | edge_inc[CNT_W];
      if (gate_q == GATE_LAST) begin
        freq_d  = edge_inc[CNT_W-1:0];
        ovf_d   = sat_q | edge_inc[CNT_W];
        valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    busy     = (state_q != IDLE);
    valid    = valid_q;
    freq_out = freq_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_frequency_meter.sv
// Scoreboard bench for frequency_meter: a one-shot narrow-counter instance and a continuous
// instance share one predetermined random sig_in waveform; expectations come from edge counting.
module tb_frequency_meter;

  localparam int G       = 100;
  localparam int NW      = 4096;
  localparam int END_CYC = 3000;
  localparam int A_MAX   = 31;
  localparam int B_MAX   = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig_in = 1'b0;
  logic       start = 1'b0;
  logic [4:0] a_freq;
  logic       a_valid, a_busy, a_ovf;
  logic [7:0] b_freq;
  logic       b_valid, b_busy, b_ovf;

  always #5 clk = ~clk;

  frequency_meter #(.GATE_CYCLES(G), .CNT_W(5), .CONTINUOUS(0)) dut_a (
    .clk_50mhz(clk), .rst(rst), .sig_in(sig_in), .start(start),
    .freq_out(a_freq), .valid(a_valid), .busy(a_busy), .overflow(a_ovf)
  );

  frequency_meter #(.GATE_CYCLES(G), .CNT_W(8), .CONTINUOUS(1)) dut_b (
    .clk_50mhz(clk), .rst(rst), .sig_in(sig_in), .start(start),
    .freq_out(b_freq), .valid(b_valid), .busy(b_busy), .overflow(b_ovf)
  );

  typedef struct {int due; int freq; bit ovf;} exp_t;

  int   cyc = 0;
  bit   wave [NW];
  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_rst = 0;
  int   a_last = -100000;
  int   b_next = 0;
  int   a_hold_f = 0;
  bit   a_hold_o = 1'b0;
  int   b_hold_f = 0;
  bit   b_hold_o = 1'b0;
  bit   a_exp_v, b_exp_v;
  exp_t a_e, b_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchroniser contents are zero after reset, so older samples read as low.
  function automatic bit w(input int j);
    if (j < 0 || j <= last_rst) return 1'b0;
    return wave[j];
  endfunction

  // A gate started from cycle s spans cycles s+1..s+G; a pin edge between cycles j-1 and j
  // produces its rise pulse two cycles later, in cycle j+2.
  function automatic exp_t predict(input int s, input int maxv);
    exp_t e;
    int   raw = 0;
    for (int j = s - 1; j <= s + G - 2; j++)
      if (!w(j - 1) && w(j)) raw++;
    e.due  = s + G + 1;
    e.ovf  = (raw > maxv);
    e.freq = e.ovf ? maxv : raw;
    return e;
  endfunction

  task automatic fill(input int from, input int to, input int period, input int high);
    for (int c = from; c < to && c < NW; c++)
      wave[c] = ((c - from) % period) < high;
  endtask

  task automatic build_wave();
    int c, len, kind, p;
    fill(0, 400, 10, 5);
    fill(400, 520, 4, 2);
    fill(520, 640, 1, 0);
    fill(640, 760, 2, 1);
    fill(760, 1200, 10, 5);
    c = 1200;
    while (c < NW) begin
      len  = $urandom_range(60, 300);
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        fill(c, c + len, 1, $urandom_range(0, 1));
      end else if (kind == 2) begin
        for (int k = c; k < c + len && k < NW; k++) wave[k] = 1'($urandom_range(0, 1));
      end else begin
        p = $urandom_range(2, 30);
        fill(c, c + len, p, $urandom_range(1, p - 1));
      end
      c += len;
    end
  endtask

  task automatic purge(input int c);
    exp_t ka[$];
    exp_t kb[$];
    foreach (qa[i]) if (qa[i].due <= c) ka.push_back(qa[i]);
    foreach (qb[i]) if (qb[i].due <= c) kb.push_back(qb[i]);
    qa = ka;
    qb = kb;
  endtask

  task automatic drive(input bit r, input bit s);
    @(posedge clk);
    #1;
    rst    = r;
    start  = s;
    sig_in = wave[cyc];
    if (r) begin
      last_rst = cyc;
      a_last   = -100000;
      b_next   = cyc + 1;
      purge(cyc);
    end else begin
      if (s && !(cyc >= a_last + 1 && cyc <= a_last + G + 1)) begin
        qa.push_back(predict(cyc, A_MAX));
        a_last = cyc;
      end
      if (cyc == b_next) begin
        qb.push_back(predict(cyc, B_MAX));
        b_next += G + 1;
      end
    end
  endtask

  task automatic start_at(input int c);
    while (cyc < c - 1) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
  endtask

  task automatic rst_at(input int c);
    while (cyc < c - 1) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 4) begin
      while (qa.size() > 0 && qa[0].due < cyc) begin
        check("a_missed_valid", 0, qa[0].due);
        void'(qa.pop_front());
      end
      a_exp_v = (qa.size() > 0) && (qa[0].due == cyc);
      check("a_valid", int'(a_valid), int'(a_exp_v));
      if (a_exp_v) begin
        a_e      = qa.pop_front();
        a_hold_f = a_e.freq;
        a_hold_o = a_e.ovf;
      end
      check("a_freq_out", int'(a_freq), a_hold_f);
      check("a_overflow", int'(a_ovf), int'(a_hold_o));
      if (!rst) check("a_busy", int'(a_busy), int'(cyc >= a_last + 1 && cyc <= a_last + G + 1));

      while (qb.size() > 0 && qb[0].due < cyc) begin
        check("b_missed_valid", 0, qb[0].due);
        void'(qb.pop_front());
      end
      b_exp_v = (qb.size() > 0) && (qb[0].due == cyc);
      check("b_valid", int'(b_valid), int'(b_exp_v));
      if (b_exp_v) begin
        b_e      = qb.pop_front();
        b_hold_f = b_e.freq;
        b_hold_o = b_e.ovf;
      end
      check("b_freq_out", int'(b_freq), b_hold_f);
      check("b_overflow", int'(b_ovf), int'(b_hold_o));
      if (!rst) check("b_busy", int'(b_busy), int'(cyc != last_rst + 1));

      if (rst) begin
        a_hold_f = 0;
        a_hold_o = 1'b0;
        b_hold_f = 0;
        b_hold_o = 1'b0;
      end
    end
  end

  initial begin
    bit r, s;
    build_wave();
    sig_in = wave[0];
    rst    = 1'b1;
    repeat (3) drive(1'b1, 1'b0);
    start_at(5);
    start_at(25);
    start_at(106);
    start_at(406);
    start_at(525);
    start_at(645);
    start_at(765);
    start_at(885);
    rst_at(935);
    start_at(940);
    while (cyc < END_CYC - 200) begin
      r = ($urandom_range(0, 399) == 0);
      s = !r && ($urandom_range(0, 19) == 0);
      drive(r, s);
    end
    while (cyc < END_CYC) drive(1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
